// File: rtl/vedic_seq_mul.sv
// -----------------------------------------------------------------------------
// vedic_seq_mul
//   Iterative WIDTH x WIDTH unsigned multiplier built around a single 2x2 Vedic
//   (Urdhva-Tiryakbhyam) core. Both operands are split into D = WIDTH/2 two-bit
//   digits. One digit pair is multiplied per RUN cycle, and the 4-bit partial
//   product is shifted into place and added to a 2*WIDTH-bit accumulator.
//   Each side has a valid/ready handshake.
//
// Parameters
//   WIDTH         operand width; must be even and >= 2
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid      operand pair valid
//   in_ready      operands accepted (high only in IDLE)
//   multiplicand  operand A
//   multiplier    operand B
//   out_valid     result valid (high only in DONE)
//   out_ready     sink accepts result
//   result        product A*B (2*WIDTH bits)
//   busy          high while iterating (RUN)
//
// Build option
//   ZERO_SKIP_EN  when defined, a zero operand at the accept edge goes straight
//                 to DONE with result 0, and RUN is never entered.
// -----------------------------------------------------------------------------
module vedic_seq_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int unsigned D  = WIDTH / 2;
    localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

    generate
        if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
            $error("vedic_seq_mul: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CW-1:0]        i_q, i_d;
    logic [CW-1:0]        j_q, j_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    logic                 accept;
    logic                 skip;
    logic                 last_i;
    logic                 last_j;
    logic [1:0]           a_dig;
    logic [1:0]           b_dig;
    logic [3:0]           pp;
    logic [2*WIDTH-1:0]   pp_ext;
    logic [CW+1:0]        shamt;

    // 2x2 Vedic core: vertical and crosswise products with a ripple carry.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
        logic t0, t1, t2, t3, c1;
        t0 = x[0] & y[0];
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        t3 = x[1] & y[1];
        c1 = t1 & t2;
        return {t3 & c1, t3 ^ c1, t1 ^ t2, t0};
    endfunction

    assign accept = in_valid && (state_q == StIdle);
    assign last_i = (i_q == CW'(D - 1));
    assign last_j = (j_q == CW'(D - 1));

`ifdef ZERO_SKIP_EN
    assign skip = (multiplicand == '0) || (multiplier == '0);
`else
    assign skip = 1'b0;
`endif

    // Digit select: a small mux over the D digit positions.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < int'(D); k++) begin
            if (i_q == CW'(k)) a_dig = a_q[2*k +: 2];
            if (j_q == CW'(k)) b_dig = b_q[2*k +: 2];
        end
    end

    // Partial product zero-extended, then placed at digit weight 2*(i+j).
    always_comb begin
        pp            = vedic_2x2(a_dig, b_dig);
        pp_ext        = '0;
        pp_ext[3:0]   = pp;
        shamt         = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) state_d = skip ? StDone : StRun;
            end
            StRun: begin
                if (last_i && last_j) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StRun);
        result    = acc_q;
    end

    // Datapath next-state.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        i_d   = i_q;
        j_d   = j_q;
        acc_d = acc_q;
        if (accept) begin
            a_d   = multiplicand;
            b_d   = multiplier;
            i_d   = '0;
            j_d   = '0;
            acc_d = '0;
        end else if (state_q == StRun) begin
            acc_d = acc_q + (pp_ext << shamt);
            // j runs fastest; i advances when j wraps.
            if (last_j) begin
                j_d = '0;
                i_d = last_i ? '0 : i_q + 1'b1;
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            i_q   <= i_d;
            j_q   <= j_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_vedic_seq_mul.sv
module tb_vedic_seq_mul;

    logic        clk;
    logic        rst_n;

    // WIDTH=8 instance
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  multiplicand, multiplier;
    logic [15:0] result;

    // WIDTH=2 instance
    logic        v2_in_valid, v2_in_ready, v2_out_valid, v2_out_ready, v2_busy;
    logic [1:0]  v2_a, v2_b;
    logic [3:0]  v2_result;

    int checks   = 0;
    int failures = 0;

    vedic_seq_mul #(.WIDTH(8)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .busy         (busy)
    );

    vedic_seq_mul #(.WIDTH(2)) u_dut_w2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (v2_in_valid),
        .in_ready     (v2_in_ready),
        .multiplicand (v2_a),
        .multiplier   (v2_b),
        .out_valid    (v2_out_valid),
        .out_ready    (v2_out_ready),
        .result       (v2_result),
        .busy         (v2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        int n;
        int bcnt;
        int exp_lat;
        int exp_busy;
        exp_lat  = 16;
        exp_busy = 16;
`ifdef ZERO_SKIP_EN
        // Zero operands land in DONE at the accept edge itself.
        if (v.a == 8'h00 || v.b == 8'h00) begin
            exp_lat  = 0;
            exp_busy = 0;
        end
`endif
        check({v.name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        multiplicand = v.a;
        multiplier   = v.b;
        out_ready    = (v.hold == 0);
        tick();
        // Operands must have been captured; scramble the inputs.
        in_valid     = 1'b0;
        multiplicand = ~v.a;
        multiplier   = v.b ^ 8'h5A;
        n    = 0;
        bcnt = 0;
        while (!out_valid && n < 40) begin
            if (busy) bcnt++;
            // in_valid during RUN must be ignored.
            in_valid = (n == 3);
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({v.name, ".latency"}, 32'(n), 32'(exp_lat));
        check({v.name, ".busy_cycles"}, 32'(bcnt), 32'(exp_busy));
        check({v.name, ".result"}, 32'(result), 32'(v.exp));
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check({v.name, ".hold_result"}, 32'(result), 32'(v.exp));
            check({v.name, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({v.name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({v.name, ".back_idle"}, 32'(in_ready), 32'd1);
        check({v.name, ".valid_low"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{name: "t1_03x02", a: 8'h03, b: 8'h02, exp: 16'h0006, hold: 0};
        vecs[1] = '{name: "t2_ffxff", a: 8'hFF, b: 8'hFF, exp: 16'hFE01, hold: 0};
        vecs[2] = '{name: "t3_a5x3c", a: 8'hA5, b: 8'h3C, exp: 16'h26AC, hold: 5};
        vecs[3] = '{name: "t5_00x5a", a: 8'h00, b: 8'h5A, exp: 16'h0000, hold: 0};
        vecs[4] = '{name: "v_0fxf0",  a: 8'h0F, b: 8'hF0, exp: 16'h0E10, hold: 1};
        vecs[5] = '{name: "v_80x02",  a: 8'h80, b: 8'h02, exp: 16'h0100, hold: 0};
        vecs[6] = '{name: "v_ffx01",  a: 8'hFF, b: 8'h01, exp: 16'h00FF, hold: 2};
        vecs[7] = '{name: "v_5ax00",  a: 8'h5A, b: 8'h00, exp: 16'h0000, hold: 0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        v2_in_valid  = 1'b0;
        v2_out_ready = 1'b0;
        v2_a         = '0;
        v2_b         = '0;

        #12;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.w2_in_ready", 32'(v2_in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Reset in the middle of RUN.
        in_valid     = 1'b1;
        multiplicand = 8'h7F;
        multiplier   = 8'h81;
        tick();
        in_valid = 1'b0;
        check("t4.busy_run", 32'(busy), 32'd1);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t4.out_valid", 32'(out_valid), 32'd0);
        check("t4.result", 32'(result), 32'd0);
        check("t4.in_ready", 32'(in_ready), 32'd1);
        check("t4.busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_vec('{name: "t4_10x10", a: 8'h10, b: 8'h10, exp: 16'h0100, hold: 0});

        // WIDTH=2: single RUN cycle.
        v2_in_valid = 1'b1;
        v2_a        = 2'd3;
        v2_b        = 2'd3;
        tick();
        // Keep in_valid high with new operands through RUN and DONE.
        v2_a = 2'd1;
        v2_b = 2'd1;
        check("t6.busy", 32'(v2_busy), 32'd1);
        check("t6.in_ready_run", 32'(v2_in_ready), 32'd0);
        tick();
        check("t6.out_valid", 32'(v2_out_valid), 32'd1);
        check("t6.result", 32'(v2_result), 32'h9);
        tick();
        check("t6.hold_valid", 32'(v2_out_valid), 32'd1);
        check("t6.hold_result", 32'(v2_result), 32'h9);
        v2_in_valid  = 1'b0;
        v2_out_ready = 1'b1;
        tick();
        v2_out_ready = 1'b0;
        check("t6.back_idle", 32'(v2_in_ready), 32'd1);
        check("t6.valid_low", 32'(v2_out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
